// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared types and constants for the AES-128 round sequencer.
//   ctrl_state_t   : sequencer states (IDLE, EXPAND, INIT, ROUND, DONE)
//   AES_NR         : number of AES-128 rounds
//   ROUND_W        : width of the round-key index
//   WD_W           : width of the key-expansion watchdog
//   ctrl_out_t     : bundle of the single-bit Moore strobes
//   decode_outputs : maps a state to its strobe pattern
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_NR          = 10;
  localparam int ROUND_W         = 4;
  localparam int WD_W            = 6;
  localparam int AES_EXP_TIMEOUT = 63;

  typedef logic [ROUND_W-1:0] round_idx_t;
  typedef logic [WD_W-1:0]    wd_t;

  typedef enum logic [2:0] {
    IDLE,
    EXPAND,
    INIT,
    ROUND,
    DONE
  } ctrl_state_t;

  typedef struct packed {
    logic expand_load;
    logic sel_init;
    logic en_state;
    logic last_round;
    logic busy;
    logic done;
  } ctrl_out_t;

  // Strobe pattern for the state the sequencer is about to enter.
  // first_expand marks the cycle in which EXPAND is being entered, so the
  // key-expansion start pulse lasts exactly one cycle. at_last tells whether
  // the round index being loaded is the final round.
  function automatic ctrl_out_t decode_outputs(input ctrl_state_t s,
                                               input logic        first_expand,
                                               input logic        at_last);
    ctrl_out_t o;
    o             = '0;
    o.expand_load = (s == EXPAND) && first_expand;
    o.sel_init    = (s == INIT);
    o.en_state    = (s == INIT) || (s == ROUND);
    o.last_round  = (s == ROUND) && at_last;
    o.busy        = (s == EXPAND) || (s == INIT) || (s == ROUND);
    o.done        = (s == DONE);
    return o;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for the host load request, with an arming bit so a
// level already high when reset is released cannot start an operation.
//   int_osc : system clock
//   reset   : asynchronous, active-low reset
//   sig     : level input to watch
//   rise    : high in a cycle where sig is high, was low last cycle, and has
//             been seen low at least once since reset
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic int_osc,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic sig_q;
  logic armed;

  // Delay the input by one cycle for edge detection. The armed bit latches
  // the first low sample after reset; until then a high input is never
  // treated as an edge, because sig_q resets to 0 and would otherwise make a
  // held-high level look like a fresh 0->1 transition.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      sig_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      sig_q <= sig;
      if (!sig) begin
        armed <= 1'b1;
      end
    end
  end

  assign rise = sig & ~sig_q & armed;

endmodule

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Sequencer for the AES-128 encryption core. A load edge starts the
// key-expansion unit; once it reports completion the round index steps
// 0..NR while the datapath strobes are driven, then done is raised and held.
//   int_osc     in  system clock (rising edge)
//   reset       in  asynchronous, active-low reset
//   load        in  host start request (level; rising edge starts)
//   expand_done in  key-expansion complete pulse
//   expand_load out one-cycle start pulse to key expansion
//   round       out round-key index (key-expansion counter select)
//   sel_init    out datapath loads plaintext XOR round key 0
//   en_state    out datapath state-register enable
//   last_round  out final round, MixColumns bypassed
//   busy        out operation in progress
//   done        out ciphertext valid, held until next accepted start
//   err         out key-expansion timeout, held until next accepted start
// ---------------------------------------------------------------------------
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR          = AES_NR,
  parameter int EXP_TIMEOUT = AES_EXP_TIMEOUT
) (
  input  logic                int_osc,
  input  logic                reset,
  input  logic                load,
  input  logic                expand_done,
  output logic                expand_load,
  output logic [ROUND_W-1:0]  round,
  output logic                sel_init,
  output logic                en_state,
  output logic                last_round,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam round_idx_t NR_IDX   = round_idx_t'(NR);
  localparam wd_t        WD_LIMIT = wd_t'(EXP_TIMEOUT);

  ctrl_state_t state;
  ctrl_state_t state_next;
  round_idx_t  round_next;
  wd_t         wd;
  wd_t         wd_next;
  logic        start;
  logic        accept;
  logic        timeout_hit;
  logic        err_next;
  ctrl_out_t   out_next;

  edge_detect u_load_edge (
    .int_osc (int_osc),
    .reset   (reset),
    .sig     (load),
    .rise    (start)
  );

  // A start is only honoured from IDLE or DONE; while an operation is in
  // flight the edge is simply dropped, with no queuing.
  assign accept = start && ((state == IDLE) || (state == DONE));

  // State register.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. In EXPAND the completion flag is tested before the
  // watchdog so a completion arriving on the very last allowed cycle still
  // proceeds to INIT rather than aborting.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        if (expand_done) begin
          state_next = INIT;
        end else if (wd == WD_LIMIT) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      INIT: begin
        state_next = ROUND;
      end
      ROUND: begin
        if (round == NR_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_next = EXPAND;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: computes the values every output register will hold in
  // the state being entered, so all strobes and the round index are true
  // registered Moore outputs aligned with the state register.
  // The watchdog restarts at 0 on entry to EXPAND and counts up to the limit
  // while waiting. The round index is 0 in INIT and advances once per ROUND
  // cycle; ROUND exits at NR, so it never passes NR.
  always_comb begin
    wd_next    = wd;
    round_next = round;
    err_next   = err;

    if ((state != EXPAND) && (state_next == EXPAND)) begin
      wd_next = '0;
    end else if ((state == EXPAND) && (wd != WD_LIMIT)) begin
      wd_next = wd + 1'b1;
    end

    if (state_next == INIT) begin
      round_next = '0;
    end else if (state_next == ROUND) begin
      round_next = round + 1'b1;
    end

    if (accept) begin
      err_next = 1'b0;
    end else if (timeout_hit) begin
      err_next = 1'b1;
    end

    out_next = decode_outputs(state_next, state != EXPAND, round_next == NR_IDX);
  end

  // Output and counter registers. Reset clears everything at once, which is
  // what aborts an operation mid-flight without ever raising done.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      wd          <= '0;
      round       <= '0;
      err         <= 1'b0;
      expand_load <= 1'b0;
      sel_init    <= 1'b0;
      en_state    <= 1'b0;
      last_round  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      wd          <= wd_next;
      round       <= round_next;
      err         <= err_next;
      expand_load <= out_next.expand_load;
      sel_init    <= out_next.sel_init;
      en_state    <= out_next.en_state;
      last_round  <= out_next.last_round;
      busy        <= out_next.busy;
      done        <= out_next.done;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Self-checking bench for aes_round_ctrl. Expected outputs come from a
// timeline model: given the cycle k after the start edge and the cycle E in
// which expand_done is pulsed, it states what every output must be.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

  localparam int NR            = 10;
  localparam int EXP_TIMEOUT   = 63;
  // The watchdog reads 0 in the first EXPAND cycle and EXP_TIMEOUT in
  // EXPAND cycle EXP_TIMEOUT+1, which is therefore the last EXPAND cycle.
  localparam int LAST_EXPAND_K = EXP_TIMEOUT + 1;

  logic       int_osc     = 1'b0;
  logic       reset       = 1'b1;
  logic       load        = 1'b0;
  logic       expand_done = 1'b0;
  logic       expand_load;
  logic [3:0] round;
  logic       sel_init;
  logic       en_state;
  logic       last_round;
  logic       busy;
  logic       done;
  logic       err;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  typedef struct packed {
    logic       expand_load;
    logic [3:0] round;
    logic       sel_init;
    logic       en_state;
    logic       last_round;
    logic       busy;
    logic       done;
    logic       err;
    logic       checkRound;
  } expect_t;

  aes_round_ctrl dut (
    .int_osc     (int_osc),
    .reset       (reset),
    .load        (load),
    .expand_done (expand_done),
    .expand_load (expand_load),
    .round       (round),
    .sel_init    (sel_init),
    .en_state    (en_state),
    .last_round  (last_round),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 int_osc = ~int_osc;

  // Timeline model of one operation. k = 1 is the cycle after the start
  // edge; e is the cycle carrying expand_done (0 = never).
  function automatic expect_t modelAt(input int k, input int e);
    expect_t x;
    bit      timedOut;
    int      lastExp;
    int      r;
    x        = '0;
    timedOut = (e == 0) || (e > LAST_EXPAND_K);
    lastExp  = timedOut ? LAST_EXPAND_K : e;
    if (k <= lastExp) begin
      x.busy        = 1'b1;
      x.expand_load = (k == 1);
    end else if (timedOut) begin
      x.err = 1'b1;
    end else begin
      r = k - lastExp - 1;
      if (r == 0) begin
        x.sel_init   = 1'b1;
        x.en_state   = 1'b1;
        x.busy       = 1'b1;
        x.round      = 4'd0;
        x.checkRound = 1'b1;
      end else if (r <= NR) begin
        x.en_state   = 1'b1;
        x.busy       = 1'b1;
        x.round      = 4'(r);
        x.last_round = (r == NR);
        x.checkRound = 1'b1;
      end else begin
        x.done = 1'b1;
      end
    end
    return x;
  endfunction

  task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input expect_t x);
    checkOne({tag, " expand_load"}, {3'b0, expand_load}, {3'b0, x.expand_load});
    checkOne({tag, " sel_init"},    {3'b0, sel_init},    {3'b0, x.sel_init});
    checkOne({tag, " en_state"},    {3'b0, en_state},    {3'b0, x.en_state});
    checkOne({tag, " last_round"},  {3'b0, last_round},  {3'b0, x.last_round});
    checkOne({tag, " busy"},        {3'b0, busy},        {3'b0, x.busy});
    checkOne({tag, " done"},        {3'b0, done},        {3'b0, x.done});
    checkOne({tag, " err"},         {3'b0, err},         {3'b0, x.err});
    if (x.checkRound) begin
      checkOne({tag, " round"}, round, x.round);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic xd);
    load        = ld;
    expand_done = xd;
  endtask

  task automatic tick();
    @(posedge int_osc);
    #1;
  endtask

  // Quiet cycles with load low; stray expand_done pulses must be ignored.
  task automatic idleCycles(input int n, input logic expErr, input logic expDone);
    expect_t x;
    for (int i = 0; i < n; i++) begin
      tick();
      x      = '0;
      x.err  = expErr;
      x.done = expDone;
      checkOutput($sformatf("idle%0d", i), x);
      applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  // One operation: present a load edge, pulse expand_done in cycle e,
  // optionally re-pulse load at a given round or reset at a given round.
  task automatic runOp(input string name, input int e, input int reloadRound,
                       input int abortRound, input int tail);
    expect_t x;
    int      kEnd;
    logic    ld;
    logic    xd;
    bit      timedOut;
    timedOut = (e == 0) || (e > LAST_EXPAND_K);
    kEnd     = timedOut ? LAST_EXPAND_K + tail : e + 11 + tail;
    applyStimulus(1'b1, 1'b0);
    for (int k = 1; k <= kEnd; k++) begin
      tick();
      x = modelAt(k, e);
      checkOutput($sformatf("%s k=%0d", name, k), x);
      if (abortRound >= 0 && x.checkRound && x.round == 4'(abortRound)) begin
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #1;
        x            = '0;
        x.checkRound = 1'b1;
        checkOutput({name, " in_reset"}, x);
        #2;
        reset = 1'b1;
        return;
      end
      ld = (k < 3) || (reloadRound >= 0 && x.checkRound && x.round == 4'(reloadRound));
      xd = (k == e) || (x.done && k == e + 12);
      applyStimulus(ld, xd);
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    expect_t x;
    int      e;

    #2 reset = 1'b0;
    #10;
    x            = '0;
    x.checkRound = 1'b1;
    checkOutput("reset_state", x);
    #1 reset = 1'b1;

    idleCycles(3, 1'b0, 1'b0);
    runOp("nominal", 45, -1, -1, 3);
    idleCycles(2, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      e = $urandom_range(1, 60);
      runOp($sformatf("rand%0d", i), e, $urandom_range(1, 9), -1, 2);
      idleCycles($urandom_range(1, 4), 1'b0, 1'b1);
    end

    runOp("timeout", 0, -1, -1, 3);
    idleCycles(2, 1'b1, 1'b0);
    runOp("clear_err", $urandom_range(1, 20), -1, -1, 2);

    runOp("wd_race", LAST_EXPAND_K, -1, -1, 3);
    runOp("late_done", LAST_EXPAND_K + 1, -1, -1, 3);
    idleCycles(1, 1'b1, 1'b0);

    // load held high through reset release must not start anything
    applyStimulus(1'b1, 1'b0);
    reset = 1'b0;
    #3;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      x = '0;
      checkOutput($sformatf("held_load%0d", i), x);
    end
    applyStimulus(1'b0, 1'b0);
    tick();
    x = '0;
    checkOutput("held_load_low", x);
    runOp("after_held", $urandom_range(1, 50), -1, -1, 2);

    runOp("abort", $urandom_range(1, 30), -1, 5, 0);
    idleCycles(2, 1'b0, 1'b0);
    runOp("post_abort", 45, -1, -1, 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
